cfg_chain_loader: RTL and testbench

- Master end of the serial configuration chain used by the switch boxes.
- Accepts configuration words over a valid/ready stream and serializes them MSB-first onto the chain.
- Drives the chain's data-in, shift-enable and config-mode lines, and reports done or error.
- Sits between the bitstream source (host/SPI bridge) and the first tile of a daisy-chained SB/CLB column.

---
 rtl/cfg_chain_loader.sv | 162 ++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// Serial configuration chain master: streams words MSB-first into the SB/CLB chain.
// Define CFG_READBACK_EN to add a VERIFY pass that rotates the chain and CRC-8 checks it.
module cfg_chain_loader #(
    parameter  int WORD_W    = 32,
    parameter  int CHAIN_LEN = 256,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              cfg_data,
    output logic              cfg_shift,
    output logic              cfg_mode,
    input  logic              cfg_data_ret,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int WC_W = $clog2(WORD_W);

`ifdef CFG_READBACK_EN
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, VERIFY, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE} state_t;
`endif

    state_t            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WC_W-1:0]   wcnt_q;
    logic              cfg_data_q;
    logic              cfg_shift_q;
    logic              cfg_mode_q;
    logic              error_q;
    logic              abort_hit;
    logic              last_bit;
    logic              last_wbit;

    // The bit being shifted this cycle is the final one of the chain / of the word.
    assign last_bit  = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign last_wbit = (wcnt_q == WC_W'(WORD_W - 1));

`ifdef CFG_READBACK_EN
    logic [7:0] crc_tx_q;
    logic [7:0] crc_rx_q;
    logic [7:0] crc_rx_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    assign crc_rx_d  = crc8_step(crc_rx_q, cfg_data_ret);
    assign abort_hit = abort && (state_q == FETCH || state_q == SHIFT || state_q == VERIFY);
    // During readback the chain output is fed straight back to its input.
    assign cfg_data  = (state_q == VERIFY) ? cfg_data_ret : cfg_data_q;
`else
    logic unused_ret;
    assign unused_ret = cfg_data_ret;
    assign abort_hit  = abort && (state_q == FETCH || state_q == SHIFT);
    assign cfg_data   = cfg_data_q;
`endif

    assign s_ready   = (state_q == FETCH);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign cfg_shift = cfg_shift_q;
    assign cfg_mode  = cfg_mode_q;
    assign error     = error_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            cfg_data_q  <= 1'b0;
            cfg_shift_q <= 1'b0;
            cfg_mode_q  <= 1'b0;
            error_q     <= 1'b0;
`ifdef CFG_READBACK_EN
            crc_tx_q    <= '0;
            crc_rx_q    <= '0;
`endif
        end else if (abort_hit) begin
            // Chain contents are left partially loaded; only the control lines drop.
            state_q     <= IDLE;
            cfg_data_q  <= 1'b0;
            cfg_shift_q <= 1'b0;
            cfg_mode_q  <= 1'b0;
            error_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= FETCH;
                        error_q    <= 1'b0;
                        cnt_q      <= '0;
                        cfg_mode_q <= 1'b1;
`ifdef CFG_READBACK_EN
                        crc_tx_q   <= '0;
                        crc_rx_q   <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (s_valid) begin
                        state_q     <= SHIFT;
                        cfg_data_q  <= s_data[WORD_W-1];
                        shreg_q     <= {s_data[WORD_W-2:0], 1'b0};
                        cfg_shift_q <= 1'b1;
                        wcnt_q      <= '0;
                    end
                end
                SHIFT: begin
                    cnt_q      <= cnt_q + CNT_W'(1);
                    wcnt_q     <= wcnt_q + WC_W'(1);
                    cfg_data_q <= shreg_q[WORD_W-1];
                    shreg_q    <= {shreg_q[WORD_W-2:0], 1'b0};
`ifdef CFG_READBACK_EN
                    crc_tx_q   <= crc8_step(crc_tx_q, cfg_data_q);
`endif
                    if (last_bit) begin
                        cfg_data_q <= 1'b0;
`ifdef CFG_READBACK_EN
                        state_q    <= VERIFY;
                        cnt_q      <= '0;
`else
                        state_q     <= DONE;
                        cfg_shift_q <= 1'b0;
                        cfg_mode_q  <= 1'b0;
`endif
                    end else if (last_wbit) begin
                        state_q     <= FETCH;
                        cfg_data_q  <= 1'b0;
                        cfg_shift_q <= 1'b0;
                    end
                end
`ifdef CFG_READBACK_EN
                VERIFY: begin
                    cnt_q    <= cnt_q + CNT_W'(1);
                    crc_rx_q <= crc_rx_d;
                    if (last_bit) begin
                        state_q     <= DONE;
                        cfg_shift_q <= 1'b0;
                        cfg_mode_q  <= 1'b0;
                        if (crc_rx_d != crc_tx_q)
                            error_q <= 1'b1;
                    end
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: behavioural chain models plus a per-bit scoreboard.
// Build with CFG_READBACK_EN to exercise the readback pass.
module tb_cfg_chain_loader;
    localparam int WW  = 32;
    localparam int CL  = 256;
    localparam int CL2 = 40;
`ifdef CFG_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    // main instance (256-bit chain)
    logic          start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_ready, cfg_data, cfg_shift, cfg_mode, cfg_data_ret, busy, done, error;
    // short instance (40-bit chain, truncated last word)
    logic          start_b = 1'b0, abort_b = 1'b0, s_valid_b = 1'b0;
    logic [WW-1:0] s_data_b = '0;
    logic          s_ready_b, cfg_data_b, cfg_shift_b, cfg_mode_b, cfg_data_ret_b, busy_b, done_b, error_b;

    cfg_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) u_dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cfg_data(cfg_data), .cfg_shift(cfg_shift), .cfg_mode(cfg_mode),
        .cfg_data_ret(cfg_data_ret), .busy(busy), .done(done), .error(error)
    );

    cfg_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL2)) u_dut_b (
        .clk(clk), .nrst(nrst), .start(start_b), .abort(abort_b),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
        .cfg_data(cfg_data_b), .cfg_shift(cfg_shift_b), .cfg_mode(cfg_mode_b),
        .cfg_data_ret(cfg_data_ret_b), .busy(busy_b), .done(done_b), .error(error_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // chain models: input at bit 0, config_data_out is the top bit
    logic [CL-1:0]  ch;
    logic [CL2-1:0] ch_b;
    logic           stuck17 = 1'b0;

    always @(posedge clk or negedge nrst)
        if (!nrst) ch <= '0;
        else if (cfg_shift) ch <= {ch[CL-2:0], cfg_data} & ~({{(CL-1){1'b0}}, stuck17} << 17);

    always @(posedge clk or negedge nrst)
        if (!nrst) ch_b <= '0;
        else if (cfg_shift_b) ch_b <= {ch_b[CL2-2:0], cfg_data_b};

    assign cfg_data_ret   = ch[CL-1];
    assign cfg_data_ret_b = ch_b[CL2-1];

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [WW-1:0] words [8];
    logic          exp_q [$];
    logic          q_b [$];
    int            gen = 0;
    logic          feed_en = 1'b0;
    int            vmode = 0;
    int            nshift, done_cnt, t_start, lat;

    // word source: s_valid either held high (vmode 0) or toggled every 5 cycles
    initial begin
        int  seen = 0, widx = 0, tick = 0, pushed = 0;
        bit  hs_pend = 0;
        forever begin
            @(negedge clk);
            if (gen != seen) begin
                seen = gen; widx = 0; tick = 0; pushed = 0; hs_pend = 0;
                exp_q.delete();
            end
            if (!feed_en) begin
                s_valid = 1'b0;
                hs_pend = 0;
            end else begin
                if (hs_pend) widx++;
                tick++;
                s_valid = (widx < 8) && (vmode == 0 || ((tick / 5) % 2) == 0);
                s_data  = (widx < 8) ? words[widx] : '0;
                hs_pend = s_valid && s_ready;
                if (hs_pend)
                    for (int b = WW - 1; b >= 0; b--)
                        if (pushed < CL) begin
                            exp_q.push_back(s_data[b]);
                            pushed++;
                        end
            end
        end
    end

    // main monitor: pops one expected bit per shift of the load phase
    initial begin
        int seen = 0;
        forever begin
            @(negedge clk);
            if (gen != seen) begin
                seen = gen; nshift = 0; done_cnt = 0;
            end
            if (done) done_cnt++;
            if (s_ready) chk("fetch_shift", cfg_shift, 0);
            if (cfg_shift) begin
                chk("mode", cfg_mode, 1);
                if (nshift < CL) begin
                    chk("sb_avail", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk($sformatf("bit%0d", nshift), cfg_data, exp_q.pop_front());
                end else begin
                    chk("rb_loop", cfg_data, ch[CL-1]);
                end
                nshift++;
            end
        end
    end

    int         nsh_b = 0;
    logic [7:0] last8_b = '0;
    initial forever begin
        @(negedge clk);
        if (cfg_shift_b) begin
            if (nsh_b < CL2) begin
                chk("b_sb_avail", q_b.size() > 0, 1);
                if (q_b.size() > 0) chk($sformatf("b_bit%0d", nsh_b), cfg_data_b, q_b.pop_front());
                last8_b = {last8_b[6:0], cfg_data_b};
            end
            nsh_b++;
        end
    end

    task automatic start_load(input int vm);
        @(negedge clk);
        gen++;
        vmode   = vm;
        feed_en = 1'b1;
        start   = 1'b1;
        t_start = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        lat = cyc - t_start;
        chk("done_outs", {cfg_shift, cfg_mode, busy, s_ready}, 4'b0010);
        feed_en = 1'b0;
        @(negedge clk);
        chk("done_pulse", {done, busy}, 2'b00);
        chk("done_cnt", done_cnt, 1);
        chk("nshift", nshift, CL * (1 + RB));
        chk("sb_left", exp_q.size(), 0);
    endtask

    initial begin
        int        k, wb;
        bit        hs;
        logic [WW-1:0] w_b [3];

        for (int i = 0; i < 8; i++) words[i] = WW'(i + 1);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle", {cfg_data, cfg_shift, cfg_mode, s_ready, busy, done, error}, 7'b0);
        chk("idle_b", {cfg_data_b, cfg_shift_b, cfg_mode_b, s_ready_b, busy_b, done_b, error_b}, 7'b0);

        // back-to-back load of words 1..8; DONE is the 265th cycle after the start cycle
        start_load(0);
        chk("start_outs", {busy, s_ready, cfg_mode, cfg_shift, error}, 5'b11100);
        wait_done(1000);
        chk("latency", lat, 264 + RB * CL);
        chk("err_a", error, 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("chain_w%0d", i), ch[CL - 1 - WW * i -: WW], words[i]);

        // abort on the 100th shift cycle
        start_load(0);
        k = 0;
        for (int n = 0; n < 1000 && k < 100; n++) begin
            @(negedge clk);
            if (cfg_shift) k++;
        end
        chk("abort_reach", k, 100);
        abort = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        feed_en = 1'b0;
        chk("abort_outs", {busy, cfg_mode, cfg_shift, done, error}, 5'b00001);
        repeat (5) @(negedge clk);
        chk("abort_nodone", done_cnt, 0);
        chk("abort_hold", {busy, error}, 2'b01);
        chk("abort_shifts", nshift, 100);

        // restart with s_valid toggling: error clears, contents match the first load
        start_load(1);
        chk("restart", {busy, error}, 2'b10);
        wait_done(4000);
        chk("stall_lat", lat > 264 + RB * CL, 1);
        chk("err_stall", error, 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("stall_w%0d", i), ch[CL - 1 - WW * i -: WW], words[i]);

        // chain bit 17 stuck at 0 with data bit 17 set: only the readback pass can see it
        for (int i = 0; i < 8; i++) words[i] = '1;
        stuck17 = 1'b1;
        start_load(0);
        wait_done(1000);
        chk("stuck_err", error, RB);
        stuck17 = 1'b0;

        // 40-bit chain: 32 ones then only the top byte (A5) of the second word
        w_b[0] = 32'hFFFF_FFFF;
        w_b[1] = 32'hA500_0000;
        w_b[2] = '0;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wb = 0;
        k  = 0;
        for (int n = 0; n < 400 && !done_b; n++) begin
            s_valid_b = (wb < 2);
            s_data_b  = w_b[wb];
            hs = s_valid_b && s_ready_b;
            if (hs)
                for (int b = WW - 1; b >= 0; b--)
                    if (k < CL2) begin
                        q_b.push_back(s_data_b[b]);
                        k++;
                    end
            @(negedge clk);
            if (hs) wb++;
        end
        s_valid_b = 1'b0;
        chk("b_done", done_b, 1);
        chk("b_nshift", nsh_b, CL2 * (1 + RB));
        chk("b_last8", last8_b, 8'hA5);
        chk("b_chain", ch_b, {32'hFFFF_FFFF, 8'hA5});
        chk("b_sb_left", q_b.size(), 0);
        chk("b_err", error_b, 0);
        @(negedge clk);
        chk("b_idle", {busy_b, done_b, cfg_mode_b}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
